// File: rtl/mesh_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mesh_pkg : shared types for the mesh receive arbiter                  |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
package mesh_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mesh_recv_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mesh_recv_arbiter_if : four inbound links plus the tile receive port  |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
interface mesh_recv_arbiter_if
  import mesh_pkg::*;
#(
  parameter int CNT_W = 16
);

  word              up_recv_data;
  logic             up_recv_valid;
  logic             up_recv_ready;
  word              down_recv_data;
  logic             down_recv_valid;
  logic             down_recv_ready;
  word              left_recv_data;
  logic             left_recv_valid;
  logic             left_recv_ready;
  word              right_recv_data;
  logic             right_recv_valid;
  logic             right_recv_ready;

  word              recv_data;
  dir_t             recv_dir;
  logic             recv_valid;
  logic             recv;
  logic [CNT_W-1:0] recv_count;

  // Arbiter side
  modport slave (
    input  up_recv_data, up_recv_valid,
    input  down_recv_data, down_recv_valid,
    input  left_recv_data, left_recv_valid,
    input  right_recv_data, right_recv_valid,
    output up_recv_ready, down_recv_ready, left_recv_ready, right_recv_ready,
    output recv_data, recv_dir, recv_valid, recv_count,
    input  recv
  );

  // Link wiring and tile core side
  modport master (
    output up_recv_data, up_recv_valid,
    output down_recv_data, down_recv_valid,
    output left_recv_data, left_recv_valid,
    output right_recv_data, right_recv_valid,
    input  up_recv_ready, down_recv_ready, left_recv_ready, right_recv_ready,
    input  recv_data, recv_dir, recv_valid, recv_count,
    output recv
  );

endinterface
`default_nettype wire

// File: rtl/mesh_recv_arbiter_rr_pick4.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_pick4 : combinational 4-way picker, search begins at start         |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       gnt_any,
  output logic [1:0] gnt_idx
);

  logic [1:0] idx;

  // Walk from the farthest offset back to start so the nearest request wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mesh_recv_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mesh_recv_arbiter : merges four mesh links into one tile receive port |
// | MESH_ARB_FAIR_EN selects round-robin, otherwise fixed priority.       |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
module mesh_recv_arbiter
  import mesh_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  mesh_recv_arbiter_if.slave bus
);

  arb_state_t       state_q, state_d;
  word              data_q, data_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0] req;
  logic [1:0] start;
  logic [1:0] gnt_idx;
  logic       gnt_any;
  logic       can_accept;
  logic       grant;
  word        link_data;

  assign req = {bus.right_recv_valid, bus.left_recv_valid,
                bus.down_recv_valid, bus.up_recv_valid};

`ifdef MESH_ARB_FAIR_EN
  dir_t last_q, last_d;

  assign start = 2'(last_q) + 2'd1;

  always_comb begin
    last_d = last_q;
    if (grant) last_d = dir_t'(gnt_idx);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) last_q <= RIGHT;
    else       last_q <= last_d;
  end
`else
  assign start = 2'd0;
`endif

  rr_pick4 u_pick (
    .req     (req),
    .start   (start),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // Readies stay low while reset is held even though the state reads EMPTY.
  assign can_accept = nrst && ((state_q == EMPTY) || bus.recv);
  assign grant      = can_accept && gnt_any;

  assign bus.up_recv_ready    = grant && (gnt_idx == 2'd0);
  assign bus.down_recv_ready  = grant && (gnt_idx == 2'd1);
  assign bus.left_recv_ready  = grant && (gnt_idx == 2'd2);
  assign bus.right_recv_ready = grant && (gnt_idx == 2'd3);

  always_comb begin
    link_data = bus.up_recv_data;
    case (gnt_idx)
      2'd1:    link_data = bus.down_recv_data;
      2'd2:    link_data = bus.left_recv_data;
      2'd3:    link_data = bus.right_recv_data;
      default: link_data = bus.up_recv_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    count_d = count_q;
    if (grant) begin
      state_d = FULL;
      data_d  = link_data;
      dir_d   = dir_t'(gnt_idx);
      count_d = count_q + CNT_W'(1);
    end else if ((state_q == FULL) && bus.recv) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      dir_q   <= UP;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      count_q <= count_d;
    end
  end

  assign bus.recv_valid = (state_q == FULL);
  assign bus.recv_data  = data_q;
  assign bus.recv_dir   = dir_q;
  assign bus.recv_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mesh_recv_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mesh_recv_arbiter : directed bench with a transaction-level model  |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
module tb_mesh_recv_arbiter;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MOD  = 1 << TB_CNT_W;
`ifdef MESH_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk;
  logic nrst;
  int   checks;
  int   fails;

  mesh_recv_arbiter_if #(.CNT_W(TB_CNT_W)) bus ();

  mesh_recv_arbiter #(.CNT_W(TB_CNT_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a one-slot buffer, an accepted-word counter and the last winner.
  bit          m_full;
  logic [31:0] m_data;
  int          m_dir;
  int          m_count;
  int          m_last;
  logic [3:0]  vv;
  logic [31:0] din [4];

  always_comb begin
    vv     = {bus.right_recv_valid, bus.left_recv_valid, bus.down_recv_valid, bus.up_recv_valid};
    din[0] = bus.up_recv_data;
    din[1] = bus.down_recv_data;
    din[2] = bus.left_recv_data;
    din[3] = bus.right_recv_data;
  end

  // Winning link this cycle, or -1 when no word may be taken.
  function automatic int exp_grant();
    int s;
    if (!nrst) return -1;
    if (m_full && !bus.recv) return -1;
    s = FAIR ? (m_last + 1) % 4 : 0;
    for (int k = 0; k < 4; k++)
      if (vv[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_full  <= 1'b0;
      m_data  <= '0;
      m_dir   <= 0;
      m_count <= 0;
      m_last  <= 3;
    end else if (exp_grant() >= 0) begin
      m_full  <= 1'b1;
      m_data  <= din[exp_grant()];
      m_dir   <= exp_grant();
      m_count <= (m_count + 1) % CNT_MOD;
      m_last  <= exp_grant();
    end else if (bus.recv) begin
      m_full  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("up_ready",    32'(bus.up_recv_ready),    32'(exp_grant() == 0));
    chk("down_ready",  32'(bus.down_recv_ready),  32'(exp_grant() == 1));
    chk("left_ready",  32'(bus.left_recv_ready),  32'(exp_grant() == 2));
    chk("right_ready", 32'(bus.right_recv_ready), 32'(exp_grant() == 3));
    chk("recv_valid",  32'(bus.recv_valid),       32'(m_full));
    chk("recv_data",   bus.recv_data,             m_data);
    chk("recv_dir",    32'(bus.recv_dir),         32'(m_dir));
    chk("recv_count",  32'(bus.recv_count),       32'(m_count));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_links(input logic [3:0] v);
    bus.up_recv_valid    = v[0];
    bus.down_recv_valid  = v[1];
    bus.left_recv_valid  = v[2];
    bus.right_recv_valid = v[3];
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    nrst   = 1'b0;
    bus.recv = 1'b0;
    bus.up_recv_data    = 32'h0000_0100;
    bus.down_recv_data  = 32'h0000_0200;
    bus.left_recv_data  = 32'h0000_0300;
    bus.right_recv_data = 32'h0000_0400;
    set_links(4'b1111);
    tick();
    tick();

    // Held reset blocks every ready even with all links valid
    chk("rst_up_ready",    32'(bus.up_recv_ready),    32'd0);
    chk("rst_down_ready",  32'(bus.down_recv_ready),  32'd0);
    chk("rst_left_ready",  32'(bus.left_recv_ready),  32'd0);
    chk("rst_right_ready", 32'(bus.right_recv_ready), 32'd0);
    chk("rst_recv_valid",  32'(bus.recv_valid),       32'd0);
    nrst = 1'b1;
    #1;
    chk("first_up_ready", 32'(bus.up_recv_ready), 32'd1);
    tick();
    chk("first_dir",   32'(bus.recv_dir),   32'd0);
    chk("first_count", 32'(bus.recv_count), 32'd1);
    chk("first_data",  bus.recv_data,       32'h0000_0100);

    // Drain, then a lone left word with the tile stalled
    set_links(4'b0000);
    bus.recv = 1'b1;
    tick();
    bus.recv = 1'b0;
    bus.left_recv_data = 32'hDEAD_BEEF;
    set_links(4'b0100);
    tick();
    chk("left_valid", 32'(bus.recv_valid), 32'd1);
    chk("left_data",  bus.recv_data,       32'hDEAD_BEEF);
    chk("left_dir",   32'(bus.recv_dir),   32'd2);
    chk("left_stall_ready", 32'(bus.left_recv_ready), 32'd0);
    tick();
    chk("left_stall_ready2", 32'(bus.left_recv_ready), 32'd0);
    bus.recv = 1'b1;
    #1;
    chk("left_pop_ready", 32'(bus.left_recv_ready), 32'd1);
    tick();
    set_links(4'b0000);
    tick();
    bus.recv = 1'b0;

    // Saturated links with the tile consuming every cycle
    bus.left_recv_data = 32'h0000_0300;
    nrst = 1'b0;
    set_links(4'b1111);
    bus.recv = 1'b1;
    #5;
    nrst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stream_dir", 32'(bus.recv_dir), FAIR ? 32'(k % 4) : 32'd0);
    end
    chk("stream_count", 32'(bus.recv_count), 32'd6);

    // Pop and capture on the same edge
    set_links(4'b0000);
    tick();
    bus.recv = 1'b0;
    bus.up_recv_data = 32'h11;
    set_links(4'b0001);
    tick();
    chk("hold_data", bus.recv_data, 32'h11);
    bus.right_recv_data = 32'h22;
    set_links(4'b1000);
    bus.recv = 1'b1;
    #1;
    chk("b2b_right_ready", 32'(bus.right_recv_ready), 32'd1);
    tick();
    chk("b2b_data",  bus.recv_data,       32'h22);
    chk("b2b_dir",   32'(bus.recv_dir),   32'd3);
    chk("b2b_valid", 32'(bus.recv_valid), 32'd1);

    // Asynchronous reset while FULL, then counter wrap
    set_links(4'b0000);
    bus.recv = 1'b0;
    nrst = 1'b0;
    #1;
    chk("async_valid", 32'(bus.recv_valid), 32'd0);
    chk("async_count", 32'(bus.recv_count), 32'd0);
    #1;
    nrst = 1'b1;
    bus.up_recv_data = 32'h0000_0100;
    set_links(4'b1111);
    bus.recv = 1'b1;
    #1;
    chk("post_rst_up_ready", 32'(bus.up_recv_ready), 32'd1);
    tick();
    chk("post_rst_dir", 32'(bus.recv_dir), 32'd0);
    for (int k = 1; k < CNT_MOD; k++) tick();
    chk("wrap_count", 32'(bus.recv_count), 32'd0);

    set_links(4'b0000);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mesh_recv_arbiter.md
# mesh_recv_arbiter

Round-robin receive arbiter that merges the four inbound mesh links (up, down, left, right) into the single tile-side receive port. It sits between the tile's mesh link wiring and the tile core. It grants one link at a time, captures the word into a one-entry holding register and presents it to the tile together with its source direction. It sustains one word per cycle when the tile consumes continuously.

## Interface
- CNT_W, 16, width of the accepted-word counter.
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- {up,down,left,right}_recv_data  in  word (32)  inbound link data.
- {up,down,left,right}_recv_valid  in  1  link holds a word.
- {up,down,left,right}_recv_ready  out  1  arbiter accepts the link word this cycle.
- recv_data  out  word (32)  word presented to the tile.
- recv_dir  out  2  source of recv_data: 0 up, 1 down, 2 left, 3 right.
- recv_valid  out  1  holding register full.
- recv  in  1  tile consumes recv_data this cycle.
- recv_count  out  CNT_W  total words accepted from links; wraps modulo 2^CNT_W.

## Operation
- Link transfer occurs at a rising edge where X_recv_valid && X_recv_ready. Tile transfer occurs at a rising edge where recv && recv_valid.
- States:
  - EMPTY: holding register empty.
  - FULL: holding register holds one word.
- can_accept = (state==EMPTY) || (state==FULL && recv).
- When can_accept is high and any recv_valid is high, exactly one link is granted. Its recv_ready is driven combinationally in the same cycle; all other readies are 0.
- Readies are never asserted while can_accept is low.
- Grant order is round-robin. Search starts at (last_grant+1) mod 4 and proceeds in the order up, down, left, right, wrapping.
- last_grant updates only on a link transfer.
- On a link transfer:
  - Capture data into recv_data and the granted direction into recv_dir.
  - recv_count increments.
  - Next state is FULL.
- Transitions:
  - EMPTY→FULL on a link transfer.
  - FULL→EMPTY on recv with no link valid.
  - FULL→FULL on recv with a link transfer (back-to-back), or when recv is low.
- recv asserted while in EMPTY is ignored.
- recv_data and recv_dir hold their values while in FULL without recv, and hold stale values in EMPTY.

## Timing
- Reset values:
  - state=EMPTY, recv_valid=0, recv_data=0, recv_dir=0, recv_count=0.
  - last_grant=3, so the first search starts at up.
  - All recv_ready are 0 after reset, except as driven combinationally by the grant rule.
- Latency: a link word accepted at edge N is visible on recv_data with recv_valid=1 after edge N.
- Throughput: one word per cycle when recv is held high and links are valid.
- Reset mid-operation: the held word is discarded. Links are not notified; a word is only considered sent by a link after its ready handshake.
- recv_ready depends combinationally on recv_valid, state and recv. There is no combinational path from recv_data.

## Configuration
- MESH_ARB_FAIR_EN defined: round-robin grant as described above.
- MESH_ARB_FAIR_EN undefined: fixed priority up > down > left > right. last_grant is not implemented. All other behaviour is identical.

## Structure
- Shared package mesh_pkg holds:
  - word (32-bit).
  - dir_t enum: UP=0, DOWN=1, LEFT=2, RIGHT=3.
  - arb_state_t {EMPTY, FULL}.
- One sub-module, rr_pick4: combinational 4-way picker.
  - Inputs: req[3:0], start[1:0].
  - Outputs: gnt_any, gnt_idx[1:0].
  - Fixed-priority mode ties start to 0.

## Test plan
- Reset with all valids high → all readies 0 while nrst=0. After release: up_recv_ready=1 in cycle 0, recv_dir=0, recv_count=1.
- Only left valid with data 0xDEADBEEF; recv=0 → after one edge: recv_valid=1, recv_data=0xDEADBEEF, recv_dir=2. left_recv_ready stays 0 until recv=1.
- All four links valid continuously, recv held at 1, fair build → recv_dir sequence 0,1,2,3,0,1. recv_count=6 after 6 transfers. Fixed-priority build → recv_dir=0 every cycle.
- FULL holding 0x11, recv=1 with right valid 0x22 → same edge: pop 0x11, capture 0x22, recv_dir=3, state stays FULL.
- recv_count preset path: 2^CNT_W accepted words (CNT_W=4 override, 16 words) → recv_count wraps to 0.
- nrst pulsed low mid-stream while FULL → recv_valid=0 immediately (asynchronous). Next grant starts at up.
